// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag layout and opcode encodings used by the
// arbiter, the external ALU and the benches.
package alu_pkg;
    localparam int FLAGW = 5;

    // Flag bit positions within {C,L,F,Z,N}
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_ADDC = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_SUBC = 8'h03;
    localparam logic [7:0] OP_AND  = 8'h04;
    localparam logic [7:0] OP_OR   = 8'h05;
    localparam logic [7:0] OP_XOR  = 8'h06;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The last pointer holds the id of the most
// recent winner; on contention the other requester wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] ready
);
    logic last;

    // Grant: one-hot, suppressed while in reset
    always_comb begin
        ready = 2'b00;
        if (!reset) begin
            if (valid == 2'b11)
                ready = last ? 2'b01 : 2'b10;
            else
                ready = valid;
        end
    end

    // Pointer follows the winner of each transfer; resets to 1 so port 0 wins first
    always_ff @(posedge clk) begin
        if (reset)
            last <= 1'b1;
        else if (|ready)
            last <= ready[1];
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters through a
// two-stage pipeline (issue register S1, result register S2) with a stored
// flag register per requester and forwarding of C for back-to-back chains.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W   = 16,
    parameter int OPW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [W-1:0]     req_a0,
    input  logic [W-1:0]     req_a1,
    input  logic [W-1:0]     req_b0,
    input  logic [W-1:0]     req_b1,
    input  logic [OPW-1:0]   req_op0,
    input  logic [OPW-1:0]   req_op1,
    input  logic             req_cin0,
    input  logic             req_cin1,
    input  logic [1:0]       req_usec,
    output logic [1:0]       resp_valid,
    output logic [W-1:0]     resp_y,
    output logic [FLAGW-1:0] resp_flags,
    output logic [FLAGW-1:0] flags0,
    output logic [FLAGW-1:0] flags1,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_cin,
    input  logic [W-1:0]     alu_y,
    input  logic [FLAGW-1:0] alu_flags
);
    logic           xfer, gnt_id;
    logic [W-1:0]   g_a, g_b;
    logic [OPW-1:0] g_op;
    logic           g_cin;

    logic           s1_v, s1_id, s1_cin;
    logic [W-1:0]   s1_a, s1_b;
    logic [OPW-1:0] s1_op;

    logic             s2_v, s2_id;
    logic [W-1:0]     s2_y;
    logic [FLAGW-1:0] s2_flags;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .valid (req_valid),
        .ready (req_ready)
    );

    assign xfer   = |req_ready;
    assign gnt_id = req_ready[1];

    // Select the granted request and resolve its carry-in; an in-flight op
    // of the same requester in S1 supplies C directly from the ALU since
    // its flag write lands on this same edge.
    always_comb begin
        g_a   = gnt_id ? req_a1  : req_a0;
        g_b   = gnt_id ? req_b1  : req_b0;
        g_op  = gnt_id ? req_op1 : req_op0;
        g_cin = gnt_id ? req_cin1 : req_cin0;
        if (req_usec[gnt_id]) begin
            if (s1_v && (s1_id == gnt_id))
                g_cin = alu_flags[FLAG_C];
            else
                g_cin = gnt_id ? flags1[FLAG_C] : flags0[FLAG_C];
        end
    end

    // S1 issue register; operands hold while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v   <= 1'b0;
            s1_id  <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_op  <= '0;
            s1_cin <= 1'b0;
        end else begin
            s1_v <= xfer;
            if (xfer) begin
                s1_id  <= gnt_id;
                s1_a   <= g_a;
                s1_b   <= g_b;
                s1_op  <= g_op;
                s1_cin <= g_cin;
            end
        end
    end

    assign alu_a   = s1_a;
    assign alu_b   = s1_b;
    assign alu_op  = s1_op;
    assign alu_cin = s1_cin;

    // S2 result register plus architectural flag write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_v     <= 1'b0;
            s2_id    <= 1'b0;
            s2_y     <= '0;
            s2_flags <= '0;
            flags0   <= '0;
            flags1   <= '0;
        end else begin
            s2_v     <= s1_v;
            s2_id    <= s1_id;
            s2_y     <= alu_y;
            s2_flags <= alu_flags;
            if (s1_v && !s1_id) flags0 <= alu_flags;
            if (s1_v &&  s1_id) flags1 <= alu_flags;
        end
    end

    assign resp_valid = {s2_v & s2_id, s2_v & ~s2_id};
    assign resp_y     = s2_y;
    assign resp_flags = s2_flags;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the external ALU.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, req_usec, resp_valid;
    logic [15:0] req_a0, req_a1, req_b0, req_b1, resp_y, alu_a, alu_b, alu_y;
    logic [7:0]  req_op0, req_op1, alu_op;
    logic        req_cin0, req_cin1, alu_cin;
    logic [4:0]  resp_flags, flags0, flags1, alu_flags;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.W(16), .OPW(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_cin0(req_cin0), .req_cin1(req_cin1), .req_usec(req_usec),
        .resp_valid(resp_valid), .resp_y(resp_y), .resp_flags(resp_flags),
        .flags0(flags0), .flags1(flags1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_flags(alu_flags)
    );

    // Behavioural ALU: C carry-out, L signed less-than, F signed overflow on add
    logic [16:0] sum;
    always_comb begin
        sum = 17'd0;
        alu_y = 16'd0;
        alu_flags = 5'd0;
        case (alu_op)
            OP_ADD:  sum = {1'b0, alu_a} + {1'b0, alu_b};
            OP_ADDC: sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
            OP_SUB:  sum = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  sum = {1'b0, alu_a & alu_b};
            OP_OR:   sum = {1'b0, alu_a | alu_b};
            OP_XOR:  sum = {1'b0, alu_a ^ alu_b};
            default: sum = 17'd0;
        endcase
        alu_y = sum[15:0];
        alu_flags[FLAG_C] = sum[16];
        alu_flags[FLAG_L] = $signed(alu_a) < $signed(alu_b);
        alu_flags[FLAG_F] = (alu_op == OP_ADD || alu_op == OP_ADDC) &&
                            (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
        alu_flags[FLAG_Z] = (sum[15:0] == 16'd0);
        alu_flags[FLAG_N] = sum[15];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic usec);
        req_op0 = op; req_a0 = a; req_b0 = b; req_cin0 = cin; req_usec[0] = usec;
    endtask

    task automatic set1(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic usec);
        req_op1 = op; req_a1 = a; req_b1 = b; req_cin1 = cin; req_usec[1] = usec;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b11;
        req_usec = 2'b00;
        set0(OP_ADD, 16'h0, 16'h0, 1'b0, 1'b0);
        set1(OP_ADD, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        step();
        // Reset state
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_y", 32'(resp_y), 32'h0);
        chk("rst_resp_flags", 32'(resp_flags), 32'h0);
        chk("rst_flags0", 32'(flags0), 32'h0);
        chk("rst_flags1", 32'(flags1), 32'h0);
        chk("rst_alu", {alu_a, alu_op, 7'd0, alu_cin}, 32'h0);
        reset = 1'b0;
        req_valid = 2'b00;
        step();

        // Contention: grants 0,1,0,1, responses one edge after each transfer
        set0(OP_XOR, 16'h00F0, 16'h0F00, 1'b0, 1'b0);
        set1(OP_AND, 16'hFFFF, 16'h1234, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            req_valid = (i < 4) ? 2'b11 : 2'b00;
            #1;
            chk($sformatf("cont_ready%0d", i), 32'(req_ready),
                (i < 4) ? ((i % 2) ? 32'h2 : 32'h1) : 32'h0);
            step();
            if (i >= 1 && i <= 4) begin
                chk($sformatf("cont_rv%0d", i), 32'(resp_valid), ((i - 1) % 2) ? 32'h2 : 32'h1);
                chk($sformatf("cont_y%0d", i), 32'(resp_y), ((i - 1) % 2) ? 32'h1234 : 32'h0FF0);
            end else begin
                chk($sformatf("cont_rv%0d", i), 32'(resp_valid), 32'h0);
            end
        end
        chk("cont_flags1", 32'(flags1), 32'h08);

        // Single request on port 0
        set0(OP_ADD, 16'h0001, 16'h0002, 1'b0, 1'b0);
        req_valid = 2'b01;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        chk("single_rv_early", 32'(resp_valid), 32'h0);
        chk("single_alu_a", 32'(alu_a), 32'h1);
        step();
        chk("single_rv", 32'(resp_valid), 32'h1);
        chk("single_y", 32'(resp_y), 32'h3);
        chk("single_rflags", 32'(resp_flags), 32'h08);
        chk("single_flags0", 32'(flags0), 32'h08);
        chk("single_flags1", 32'(flags1), 32'h08);
        step();
        chk("single_rv_pulse", 32'(resp_valid), 32'h0);

        // Forwarded carry chain on port 0 (stored C0 is 0 at issue time)
        set0(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        req_valid = 2'b01;
        step();
        set0(OP_ADDC, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step();
        req_valid = 2'b00;
        chk("fwd_alu_cin", 32'(alu_cin), 32'h1);
        chk("fwd_y0", 32'(resp_y), 32'h0);
        chk("fwd_flags0", 32'(resp_flags), 32'h1A);
        step();
        chk("fwd_rv1", 32'(resp_valid), 32'h1);
        chk("fwd_y1", 32'(resp_y), 32'h1);
        chk("fwd_stored0", 32'(flags0), 32'h00);

        // Carry isolation: port 1 sets C1, port 0 chains on its own C0=0
        set1(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        req_valid = 2'b10;
        step();
        set0(OP_ADDC, 16'h0000, 16'h0000, 1'b1, 1'b1);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        chk("iso_rv1", 32'(resp_valid), 32'h2);
        step();
        chk("iso_rv0", 32'(resp_valid), 32'h1);
        chk("iso_y", 32'(resp_y), 32'h0);
        chk("iso_flags1", 32'(flags1), 32'h1A);

        // Stored (non-forwarded) C1=1, then explicit cin with usec clear
        set1(OP_ADDC, 16'h0000, 16'h0000, 1'b0, 1'b1);
        req_valid = 2'b10;
        step();
        set0(OP_ADDC, 16'h0005, 16'h0006, 1'b1, 1'b0);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        chk("stored_y", 32'(resp_y), 32'h1);
        step();
        chk("explicit_y", 32'(resp_y), 32'h000C);
        step();

        // Idle: no responses, flags hold
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle_rv%0d", i), 32'(resp_valid), 32'h0);
        end
        chk("idle_flags0", 32'(flags0), 32'h08);
        chk("idle_flags1", 32'(flags1), 32'h00);

        // Reset mid-flight: transfer, then reset on the next edge
        set0(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        reset = 1'b1;
        step();
        chk("mid_rv_a", 32'(resp_valid), 32'h0);
        chk("mid_flags0_a", 32'(flags0), 32'h0);
        reset = 1'b0;
        step();
        chk("mid_rv_b", 32'(resp_valid), 32'h0);
        chk("mid_flags0_b", 32'(flags0), 32'h0);
        req_valid = 2'b11;
        #1;
        chk("mid_last", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
